// File: rtl/ram_wport_arbiter_2w.sv
// ram_wport_arbiter_2w
// Write-side front end for a 16-entry register RAM. Two producers push
// {addr, data} writes into private 2-entry FIFOs; a round-robin arbiter
// drains them onto the RAM's single registered write port. After reset an
// init sequencer optionally clears every entry to INIT_VALUE first.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req0_valid/addr/data/ready  producer 0 valid/ready channel
//   req1_valid/addr/data/ready  producer 1 valid/ready channel
//   addrw, din, wea             registered RAM write port
//   init_done                   high once RUN is entered
//   idle                        RUN, both FIFOs empty, no write in flight
//
// state | meaning
// ------+---------------------------------------------------
// INIT  | clearing entries 0..15 with INIT_VALUE, no accepts
// RUN   | accepting producer writes, arbitrating FIFO heads
module ram_wport_arbiter_2w #(
  parameter int               WIDTH      = 32,
  parameter bit               INIT_EN    = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [3:0]       addrw,
  output logic [WIDTH-1:0] din,
  output logic             wea,
  output logic             init_done,
  output logic             idle
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [3:0]       init_cnt;
  logic             last_grant;   // 1 = port 1 granted last

  // FIFO storage per port; slot 0 is always the head
  logic [3:0]       f_addr [2][2];
  logic [WIDTH-1:0] f_data [2][2];
  logic [1:0]       cnt    [2];

  logic [3:0]       in_addr [2];
  logic [WIDTH-1:0] in_data [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             ne0, ne1;
  logic             run;

  assign in_addr[0] = req0_addr;
  assign in_addr[1] = req1_addr;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  assign run        = (state == S_RUN);
  assign req0_ready = run && (cnt[0] < 2'd2);
  assign req1_ready = run && (cnt[1] < 2'd2);
  assign push[0]    = req0_valid && req0_ready;
  assign push[1]    = req1_valid && req1_ready;

  assign ne0 = (cnt[0] != 2'd0);
  assign ne1 = (cnt[1] != 2'd0);

  // On a tie the port that did not win last time goes next
  assign pop[0] = run && ne0 && (!ne1 || last_grant);
  assign pop[1] = run && ne1 && (!ne0 || !last_grant);

  assign init_done = run;
  assign idle      = run && !ne0 && !ne1 && !wea;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        cnt[p]       <= 2'd0;
        f_addr[p][0] <= '0;
        f_addr[p][1] <= '0;
        f_data[p][0] <= '0;
        f_data[p][1] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        case ({push[p], pop[p]})
          2'b10: begin
            // count is 0 or 1 here, so its LSB is the free slot
            f_addr[p][cnt[p][0]] <= in_addr[p];
            f_data[p][cnt[p][0]] <= in_data[p];
            cnt[p]               <= cnt[p] + 2'd1;
          end
          2'b01: begin
            f_addr[p][0] <= f_addr[p][1];
            f_data[p][0] <= f_data[p][1];
            cnt[p]       <= cnt[p] - 2'd1;
          end
          2'b11: begin
            if (cnt[p] == 2'd1) begin
              f_addr[p][0] <= in_addr[p];
              f_data[p][0] <= in_data[p];
            end else begin
              f_addr[p][0] <= f_addr[p][1];
              f_data[p][0] <= f_data[p][1];
              f_addr[p][1] <= in_addr[p];
              f_data[p][1] <= in_data[p];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT_EN ? S_INIT : S_RUN;
      init_cnt   <= 4'd0;
      last_grant <= 1'b1;
      wea        <= 1'b0;
      addrw      <= 4'd0;
      din        <= '0;
    end else begin
      case (state)
        S_INIT: begin
          // Leave only after the addrw=15 clear write has been presented
          if (wea && (addrw == 4'hF)) begin
            state <= S_RUN;
            wea   <= 1'b0;
          end else begin
            wea      <= 1'b1;
            addrw    <= init_cnt;
            din      <= INIT_VALUE;
            init_cnt <= init_cnt + 4'd1;
          end
        end
        S_RUN: begin
          if (pop[0]) begin
            wea        <= 1'b1;
            addrw      <= f_addr[0][0];
            din        <= f_data[0][0];
            last_grant <= 1'b0;
          end else if (pop[1]) begin
            wea        <= 1'b1;
            addrw      <= f_addr[1][0];
            din        <= f_data[1][0];
            last_grant <= 1'b1;
          end else begin
            wea <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wport_arbiter_2w.sv
module tb_ram_wport_arbiter_2w;
  localparam int          W  = 32;
  localparam logic [31:0] IV = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]    req0_addr = '0, req1_addr = '0;
  logic [W-1:0]  req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic [3:0]    addrw;
  logic [W-1:0]  din;
  logic          wea, init_done, idle;

  ram_wport_arbiter_2w #(.WIDTH(W), .INIT_EN(1'b1), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .addrw(addrw), .din(din), .wea(wea), .init_done(init_done), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  typedef struct {logic [3:0] a; logic [31:0] d;} item_t;

  // ---------------- behavioural model ----------------
  item_t       mq0[$], mq1[$];
  bit          m_run = 0;
  int          m_idx = 0;
  bit          m_last = 1;
  logic        m_wea = 0;
  logic [3:0]  m_addr = 0;
  logic [31:0] m_din = 0;
  logic [31:0] m_mem [16];

  always @(posedge clk or negedge rst_n) begin : model
    bit    acc0, acc1;
    item_t g;
    if (!rst_n) begin
      mq0.delete(); mq1.delete();
      m_run = 0; m_idx = 0; m_last = 1;
      m_wea = 0; m_addr = 0; m_din = 0;
    end else begin
      acc0 = m_run && req0_valid && (mq0.size() < 2);
      acc1 = m_run && req1_valid && (mq1.size() < 2);
      if (!m_run) begin
        if (m_idx < 16) begin
          m_wea = 1; m_addr = m_idx[3:0]; m_din = IV;
          m_mem[m_idx] = IV;
          m_idx++;
        end else begin
          m_run = 1; m_wea = 0;
        end
      end else begin
        if (mq0.size() > 0 && (mq1.size() == 0 || m_last)) begin
          g = mq0.pop_front(); m_last = 0;
          m_wea = 1; m_addr = g.a; m_din = g.d; m_mem[g.a] = g.d;
        end else if (mq1.size() > 0) begin
          g = mq1.pop_front(); m_last = 1;
          m_wea = 1; m_addr = g.a; m_din = g.d; m_mem[g.a] = g.d;
        end else begin
          m_wea = 0;
        end
      end
      if (acc0) mq0.push_back('{req0_addr, req0_data});
      if (acc1) mq1.push_back('{req1_addr, req1_data});
    end
  end

  int cyc = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc = 0; else cyc++;

  // ---------------- compare + write log ----------------
  logic [3:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  logic [31:0] tb_ram [16];
  int          first_done_cyc = -1;

  always @(negedge clk) begin
    chk("wea", wea, m_wea);
    chk("addrw", addrw, m_addr);
    chk("din", din, m_din);
    chk("req0_ready", req0_ready, m_run && (mq0.size() < 2));
    chk("req1_ready", req1_ready, m_run && (mq1.size() < 2));
    chk("init_done", init_done, m_run);
    chk("idle", idle, m_run && mq0.size() == 0 && mq1.size() == 0 && !m_wea);
    if (rst_n && wea === 1'b1) begin
      log_addr.push_back(addrw);
      log_data.push_back(din);
      log_cyc.push_back(cyc);
      tb_ram[addrw] = din;
    end
    if (rst_n && init_done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
  end

  // ---------------- stimulus ----------------
  item_t sq0[$], sq1[$];
  int    pct0 = 100, pct1 = 100;
  bit    seen0 = 0, seen1 = 0;

  task automatic drive_cycle();
    @(negedge clk);
    #1;
    if (req0_valid && seen0) void'(sq0.pop_front());
    if (req1_valid && seen1) void'(sq1.pop_front());
    if (rst_n && sq0.size() > 0 && $urandom_range(99) < pct0) begin
      req0_valid = 1; req0_addr = sq0[0].a; req0_data = sq0[0].d;
    end else req0_valid = 0;
    if (rst_n && sq1.size() > 0 && $urandom_range(99) < pct1) begin
      req1_valid = 1; req1_addr = sq1[0].a; req1_data = sq1[0].d;
    end else req1_valid = 0;
    seen0 = req0_ready;
    seen1 = req1_ready;
  endtask

  task automatic drain(string name, int max);
    int n;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while (n < max && !(sq0.size() == 0 && sq1.size() == 0 && !req0_valid && !req1_valid &&
                           mq0.size() == 0 && mq1.size() == 0 && !m_wea));
    if (n >= max) timeout_fail(name);
  endtask

  task automatic chk_log(string name, int idx, logic [3:0] ea, logic [31:0] ed);
    if (idx >= log_addr.size()) begin
      checks++; failures++;
      $display("FAIL %s actual=missing_write required=addr_%0h", name, ea);
    end else begin
      chk({name, "_addr"}, log_addr[idx], ea);
      chk({name, "_data"}, log_data[idx], ed);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int order [8] = '{4, 8, 5, 9, 6, 10, 7, 11};

    // Reset values
    repeat (3) drive_cycle();
    chk("rst_wea", wea, 0);
    chk("rst_addrw", addrw, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_init_done", init_done, 0);
    rst_n = 1;

    // Init, with port 1 requesting during the last init cycles
    repeat (12) drive_cycle();
    sq1.push_back('{4'd3, 32'h33});
    drain("init_drain", 60);
    for (int i = 0; i < 16; i++) begin
      chk_log("init_wr", i, i[3:0], IV);
      if (i < log_cyc.size()) chk("init_wr_cyc", log_cyc[i], i + 1);
    end
    chk("init_done_edge", first_done_cyc, 17);
    chk_log("first_run_wr", 16, 4'd3, 32'h33);
    if (log_cyc.size() > 16) chk("first_run_wr_cyc", log_cyc[16], 19);
    for (int i = 0; i < 16; i++) chk("ram_after_init", tb_ram[i], (i == 3) ? 32'h33 : IV);

    // Both ports streaming; port 1 was granted last
    base = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      sq0.push_back('{4'(4 + i), 32'h40 + i});
      sq1.push_back('{4'(8 + i), 32'h80 + i});
    end
    drain("both_drain", 60);
    chk("both_count", log_addr.size() - base, 8);
    for (int k = 0; k < 8; k++)
      chk_log("both_order", base + k, order[k][3:0], (order[k] < 8) ? 32'h40 + order[k] - 4 : 32'h80 + order[k] - 8);

    // Same-address collision, port 1 granted last
    base = log_addr.size();
    sq0.push_back('{4'd5, 32'hAAAA});
    sq1.push_back('{4'd5, 32'hBBBB});
    drain("same_addr_drain", 30);
    chk_log("same_addr_first", base, 4'd5, 32'hAAAA);
    chk_log("same_addr_second", base + 1, 4'd5, 32'hBBBB);
    chk("ram5", tb_ram[5], 32'hBBBB);

    // Port 0 alone
    base = log_addr.size();
    sq0.push_back('{4'd1, 32'h11});
    sq0.push_back('{4'd2, 32'h22});
    sq0.push_back('{4'd3, 32'h33});
    drain("p0_drain", 30);
    chk_log("p0_w1", base, 4'd1, 32'h11);
    chk_log("p0_w2", base + 1, 4'd2, 32'h22);
    chk_log("p0_w3", base + 2, 4'd3, 32'h33);
    if (log_cyc.size() > base + 2) begin
      chk("p0_b2b_1", log_cyc[base + 1], log_cyc[base] + 1);
      chk("p0_b2b_2", log_cyc[base + 2], log_cyc[base] + 2);
    end
    chk("p0_idle_after", idle, 1);

    // Random traffic
    pct0 = 70; pct1 = 50;
    for (int i = 0; i < 150; i++) begin
      sq0.push_back('{4'($urandom_range(15)), $urandom});
      sq1.push_back('{4'($urandom_range(15)), $urandom});
    end
    drain("random_drain", 3000);
    for (int i = 0; i < 16; i++) chk("ram_vs_model", tb_ram[i], m_mem[i]);

    // Reset while both FIFOs hold entries
    pct0 = 100; pct1 = 100;
    for (int i = 0; i < 6; i++) begin
      sq0.push_back('{4'(i), 32'h100 + i});
      sq1.push_back('{4'(8 + i), 32'h200 + i});
    end
    n = 0;
    do begin
      drive_cycle();
      @(posedge clk);
      #2;
      n++;
    end while (n < 20 && (mq0.size() + mq1.size()) < 3);
    if (n >= 20) timeout_fail("fill_fifos");
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    sq0.delete(); sq1.delete();
    seen0 = 0; seen1 = 0;
    #1;
    chk("async_wea", wea, 0);
    chk("async_ready1", req1_ready, 0);
    first_done_cyc = -1;
    base = log_addr.size();
    repeat (2) drive_cycle();
    rst_n = 1;
    repeat (20) drive_cycle();
    chk("reinit_count", log_addr.size() - base, 16);
    for (int i = 0; i < 16; i++) chk_log("reinit_wr", base + i, i[3:0], IV);
    chk("reinit_done_edge", first_done_cyc, 17);
    for (int i = 0; i < 16; i++) chk("ram_final", tb_ram[i], m_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
